// File: rtl/tdm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_pkg : shared slot constants, RX FSM states, one-hot helpers    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tdm_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SKIP = 2'd1,
    RUN  = 2'd2
  } tdm_rx_state_t;

  function automatic logic [SLOTS-1:0] onehot4(input logic [SLOT_W-1:0] idx);
    logic [SLOTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Caller guarantees a single set bit.
  function automatic logic [SLOT_W-1:0] slot_index4(input logic [SLOTS-1:0] oh);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (oh[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_rx_fifo : small synchronous FIFO, push+pop allowed when full   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tdm_rx_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdm_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_rx : TDM slot lock, 4-slot frame reassembly, buffered output.  |
// | Define TDM_RX_ERRCNT_EN to add the err_cnt alignment-error port.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tdm_rx #(
  parameter int SLOTS = 4,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic [3:0] slot_y,
  output logic [3:0] frame_out,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       locked,
  output logic       overflow
`ifdef TDM_RX_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  import tdm_pkg::*;

  tdm_rx_state_t     state;
  tdm_rx_state_t     next_state;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] cur_slot;
  logic [SLOT_W-1:0] prev_slot;
  logic              prev_bit;
  logic [SLOTS-2:0]  shift;
  logic [3:0]        exp_y;
  logic              y_single;
  logic              hit;
  logic              mismatch;
  logic              capture;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign y_single = (slot_y != 4'b0000) && ((slot_y & (slot_y - 4'd1)) == 4'b0000);
  assign hit      = (state == HUNT) && y_single;
  // On a hit, slot_y names the previous slot, so this cycle is one beyond it.
  assign cur_slot = hit ? slot_index4(slot_y) + SLOT_W'(1) : slot_q;
  assign exp_y    = prev_bit ? onehot4(prev_slot) : 4'b0000;
  assign mismatch = (state != HUNT) && (slot_y != exp_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HUNT:    if (hit) next_state = SKIP;
      SKIP:    if (mismatch) next_state = HUNT;
               else if (slot_q == '0) next_state = RUN;
      RUN:     if (mismatch) next_state = HUNT;
      default: next_state = HUNT;
    endcase
  end

  always_comb begin
    locked  = (state != HUNT);
    capture = 1'b0;
    case (state)
      SKIP:    capture = !mismatch && (slot_q == '0);
      RUN:     capture = !mismatch;
      default: capture = 1'b0;
    endcase
    push = capture && (slot_q == SLOT_W'(SLOTS-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      prev_slot <= '0;
      prev_bit  <= 1'b0;
      shift     <= '0;
    end else begin
      slot_q    <= cur_slot + SLOT_W'(1);
      prev_slot <= cur_slot;
      prev_bit  <= data_in;
      for (int i = 0; i < SLOTS-1; i++) begin
        if (capture && (slot_q == SLOT_W'(i))) shift[i] <= data_in;
      end
    end
  end

  assign pop         = frame_valid && frame_ready;
  assign frame_valid = !fifo_empty;

  tdm_rx_fifo #(
    .WIDTH (SLOTS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({data_in, shift}),
    .pop       (pop),
    .pop_data  (frame_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overflow <= 1'b0;
    else if (push && fifo_full && !pop)     overflow <= 1'b1;
  end

`ifdef TDM_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_cnt <= '0;
    else if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
`default_nettype wire
